servo_pwm_array: RTL



---
 rtl/servo_pwm_array.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/servo_pwm_array.sv
// Multi-channel hobby-servo PWM driver. One shared frame counter feeds N_CH
// lanes. Each lane holds a clamped target angle, a slew-limited commanded
// angle and a frame-sampled enable, and drives a registered PWM pin.

module servo_pwm_lane #(
    parameter int unsigned ANGLE_W    = 8,
    parameter int unsigned CW         = 15,
    parameter int unsigned HW         = 12,
    parameter int unsigned CMPW       = 15,
    parameter int unsigned MIN_CYCLES = 1100,
    parameter int unsigned K          = 6,
    parameter int unsigned MAX_ANGLE  = 180,
    parameter int unsigned SLEW_STEP  = 2,
    parameter int unsigned INIT_ANGLE = 90
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wrap,
    input  logic [CW-1:0]      cnt_d,
    input  logic               load,
    input  logic [ANGLE_W-1:0] angle,
    input  logic               en_req,
    output logic               pwm,
    output logic               at_target
);
    localparam logic [ANGLE_W-1:0] MAX_A  = ANGLE_W'(MAX_ANGLE);
    localparam logic [ANGLE_W-1:0] STEP   = ANGLE_W'(SLEW_STEP);
    localparam logic [ANGLE_W-1:0] INIT_A = ANGLE_W'(INIT_ANGLE);
    localparam logic [HW-1:0]      K_H    = HW'(K);
    localparam logic [HW-1:0]      MIN_H  = HW'(MIN_CYCLES);

    logic [ANGLE_W-1:0] tgt_q, tgt_d, cur_q, cur_d;
    logic [ANGLE_W-1:0] angle_clamped, diff, move;
    logic [HW-1:0]      high_d;
    logic               en_q, en_d, pwm_q, pwm_d;

    // Target capture: clamp the requested angle, hold when not loading.
    always_comb begin
        angle_clamped = (angle > MAX_A) ? MAX_A : angle;
        tgt_d         = load ? angle_clamped : tgt_q;
    end

    // Frame update: step toward the pre-edge target and sample the enable.
    always_comb begin
        diff  = (tgt_q > cur_q) ? (tgt_q - cur_q) : (cur_q - tgt_q);
        move  = (diff < STEP) ? diff : STEP;
        cur_d = cur_q;
        en_d  = en_q;
        if (wrap) begin
            en_d = en_req;
            if (SLEW_STEP == 0)     cur_d = tgt_q;
            else if (tgt_q > cur_q) cur_d = cur_q + move;
            else                    cur_d = cur_q - move;
        end
    end

    // Next PWM level from next-cycle counter/angle/enable so the pin is a flop.
    always_comb begin
        high_d = HW'(cur_d) * K_H + MIN_H;
        pwm_d  = en_d && (CMPW'(cnt_d) < CMPW'(high_d));
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt_q <= INIT_A;
            cur_q <= INIT_A;
            en_q  <= 1'b0;
            pwm_q <= 1'b0;
        end else begin
            tgt_q <= tgt_d;
            cur_q <= cur_d;
            en_q  <= en_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm       = pwm_q;
    assign at_target = (cur_q == tgt_q);
endmodule

module servo_pwm_array #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned ANGLE_W       = 8,
    parameter int unsigned PERIOD_CYCLES = 23000,
    parameter int unsigned MIN_CYCLES    = 1100,
    parameter int unsigned K             = 6,
    parameter int unsigned MAX_ANGLE     = 180,
    parameter int unsigned SLEW_STEP     = 2,
    parameter int unsigned INIT_ANGLE    = 90
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_CH*ANGLE_W-1:0]   angle_in,
    input  logic                      load,
    input  logic [N_CH-1:0]           ch_en,
    output logic [N_CH-1:0]           pwm,
    output logic                      frame_start,
    output logic [N_CH-1:0]           at_target
);
    localparam int unsigned CW   = $clog2(PERIOD_CYCLES);
    localparam int unsigned HW   = $clog2(MAX_ANGLE * K + MIN_CYCLES + 1);
    localparam int unsigned CMPW = (CW > HW) ? CW : HW;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;
    logic          frame_start_q, frame_start_d;

    // Frame counter 0..PERIOD_CYCLES-1; frame_start registered against the next count.
    always_comb begin
        wrap          = (cnt_q == LAST);
        cnt_d         = wrap ? '0 : cnt_q + 1'b1;
        frame_start_d = (cnt_d == '0);
    end

    // Shared counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        servo_pwm_lane #(
            .ANGLE_W(ANGLE_W), .CW(CW), .HW(HW), .CMPW(CMPW),
            .MIN_CYCLES(MIN_CYCLES), .K(K), .MAX_ANGLE(MAX_ANGLE),
            .SLEW_STEP(SLEW_STEP), .INIT_ANGLE(INIT_ANGLE)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .wrap     (wrap),
            .cnt_d    (cnt_d),
            .load     (load),
            .angle    (angle_in[i*ANGLE_W +: ANGLE_W]),
            .en_req   (ch_en[i]),
            .pwm      (pwm[i]),
            .at_target(at_target[i])
        );
    end
endmodule
